register_file: RTL and testbench
================================

Name: register_file

Overview:
- Architectural register file at the tail of the pipeline.
- Consumes the registered write-back outputs (`reg_wen_out`, `wr_reg_out`, `alu_result_out`) and feeds two combinational read ports to the decode/execute side.
- Register 0 is hardwired to zero.
- The array has no per-flop reset. After reset, a zeroing sweep clears every register, one per cycle.

Parameters:
- WIDTH, 16, data width of each register; must match the write-back stage.
- NUM_REGS, 32, number of architectural registers; range 2..32.
- ADDR_W, 5, register address width; fixed by instruction format.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- reg_wen  input  1  write enable from write-back stage
- wr_reg  input  ADDR_W  destination register index
- wr_data  input  WIDTH  write data (write-back ALU result)
- rd_addr_a  input  ADDR_W  read port A index
- rd_addr_b  input  ADDR_W  read port B index
- rd_data_a  output  WIDTH  read port A data, combinational
- rd_data_b  output  WIDTH  read port B data, combinational
- init_busy  output  1  high while the zeroing sweep runs; upstream must stall

Behaviour:
- States: INIT, READY. A 2-state FSM with a sweep pointer `init_ptr[ADDR_W-1:0]`.
- Reset, sampled at a clk edge with rst=1:
  - state <= INIT, init_ptr <= 1, init_busy = 1.
  - Array contents are not touched by rst itself.
- INIT:
  - Each cycle writes 0 to regs[init_ptr] and increments init_ptr.
  - At the edge where init_ptr == NUM_REGS-1, that register is zeroed and state <= READY.
  - Sweep occupies exactly NUM_REGS-1 cycles after rst deasserts (31 at default).
  - External writes are ignored.
  - rd_data_a and rd_data_b are forced to 0.
- READY:
  - init_busy = 0.
  - At the clk edge with reg_wen=1, 1 <= wr_reg < NUM_REGS: regs[wr_reg] <= wr_data.
  - Writes to index 0 are dropped. Writes to index >= NUM_REGS are dropped.
- Read: rd_data_x = 0 if rd_addr_x == 0, or rd_addr_x >= NUM_REGS, or state == INIT. Otherwise rd_data_x = regs[rd_addr_x], subject to the bypass below.
- Both read ports are independent. A and B at the same address return identical data.
- rst asserted mid-sweep or mid-operation: the sweep restarts from index 1. The pointer never wraps past NUM_REGS-1.
- init_busy is a registered state decode, so it is glitch-free.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through bypass in READY. If reg_wen=1, wr_reg == rd_addr_x, wr_reg != 0 and wr_reg < NUM_REGS, then rd_data_x = wr_data in the same cycle. This covers the WB→decode hazard without a stall.
- Undefined: reads return stored array contents only; a same-cycle write is visible from the next cycle. The hazard unit must stall one cycle.

Decomposition:
- Shared package holds:
  - REG_ADDR_W = 5;
  - REG_ZERO = 0;
  - the rf_state_t enum {RF_INIT, RF_READY}.
- One natural sub-module: rf_read_port (address checks, zero forcing, optional bypass mux), instantiated twice.
- Array, write logic and FSM stay in the top.

Test Plan:
- Pulse rst for 1 cycle → init_busy=1 for exactly 31 cycles, then 0. Afterwards every read of r1..r31 returns 0x0000, even with X-initialised array.
- READY: write r5=0xBEEF, then read A=5, B=5 → both 0xBEEF on the cycle after the write edge.
- Write r0=0x1234, then read A=0 → 0x0000. Write r31=0xFFFF, then read B=31 → 0xFFFF (wrap boundary).
- During INIT, issue write r3=0xAAAA; after the sweep, read r3 → 0x0000. Assert rst at sweep cycle 10 → init_busy stays high 31 more cycles.
- Same-cycle write r7=0x5A5A with read A=7 (old value 0x0011) → 0x5A5A with REGFILE_BYPASS_EN, 0x0011 without. Next cycle → 0x5A5A in both builds.
- NUM_REGS=8 build: write r12=0x7777 → dropped. Read 12 → 0x0000. Sweep length = 7 cycles.

Source files
------------

// File: rtl/register_file_pkg.sv
// Shared definitions for the architectural register file: address width,
// the hardwired-zero index and the sweep/ready state encoding.
package register_file_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

    typedef enum logic {
        RF_INIT  = 1'b0,
        RF_READY = 1'b1
    } rf_state_t;

endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: zero forcing for r0, out-of-range indices and
// the INIT sweep, plus the write-through bypass when REGFILE_BYPASS_EN is set.
module rf_read_port
    import register_file_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = REG_ADDR_W
) (
    output logic [WIDTH-1:0]  rd_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  stored,
    input  logic              init_busy
`ifdef REGFILE_BYPASS_EN
    ,
    input  logic              reg_wen,
    input  logic [ADDR_W-1:0] wr_reg,
    input  logic [WIDTH-1:0]  wr_data
`endif
);

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    logic addr_ok;

    assign addr_ok = (rd_addr != ADDR_W'(REG_ZERO)) && ({1'b0, rd_addr} < NUM_REGS_W);

    always_comb begin
        rd_data = '0;
        if (!init_busy && addr_ok) begin
            rd_data = stored;
`ifdef REGFILE_BYPASS_EN
            // addr_ok already excludes r0 and out-of-range targets for the bypass
            if (reg_wen && (wr_reg == rd_addr)) begin
                rd_data = wr_data;
            end
`endif
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file: r0 hardwired to zero, zeroing sweep after reset,
// two combinational read ports. Optional write-through bypass: REGFILE_BYPASS_EN.
module register_file
    import register_file_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_wen,
    input  logic [ADDR_W-1:0] wr_reg,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              init_busy
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
    localparam logic ST_INIT  = RF_INIT;
    localparam logic ST_READY = RF_READY;

    logic [WIDTH-1:0]  regs [NUM_REGS];
    logic              state;
    logic [ADDR_W-1:0] init_ptr;
    logic              wr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_INIT;
            init_ptr <= ADDR_W'(1);
        end else if (state == ST_INIT) begin
            // Pointer parks on the last index so it can never wrap
            if (init_ptr == LAST_IDX) begin
                state <= ST_READY;
            end else begin
                init_ptr <= init_ptr + 1'b1;
            end
        end
    end

    assign init_busy = (state == ST_INIT);

    assign wr_ok = reg_wen && (state == ST_READY) &&
                   (wr_reg != ADDR_W'(REG_ZERO)) && ({1'b0, wr_reg} < NUM_REGS_W);

    // Storage has no reset; the sweep is what clears it
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            regs[init_ptr[IDX_W-1:0]] <= '0;
        end else if (wr_ok) begin
            regs[wr_reg[IDX_W-1:0]] <= wr_data;
        end
    end

    rf_read_port #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_port_a (
        .rd_data   (rd_data_a),
        .rd_addr   (rd_addr_a),
        .stored    (regs[rd_addr_a[IDX_W-1:0]]),
        .init_busy (init_busy)
`ifdef REGFILE_BYPASS_EN
        ,
        .reg_wen   (reg_wen),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data)
`endif
    );

    rf_read_port #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_port_b (
        .rd_data   (rd_data_b),
        .rd_addr   (rd_addr_b),
        .stored    (regs[rd_addr_b[IDX_W-1:0]]),
        .init_busy (init_busy)
`ifdef REGFILE_BYPASS_EN
        ,
        .reg_wen   (reg_wen),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data)
`endif
    );

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a 32-entry and an 8-entry instance share
// stimulus; expected read data is queued and checked once outputs settle.
module tb_register_file;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              reg_wen;
    logic [ADDR_W-1:0] wr_reg;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_a,  rd_data_b;
    logic [WIDTH-1:0]  rd8_data_a, rd8_data_b;
    logic              init_busy, init8_busy;

    int n_asserts = 0;
    int n_fail    = 0;

    typedef struct {
        string          tag;
        int             port;
        logic [WIDTH-1:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];

    always #5 clk = ~clk;

    register_file #(.WIDTH(WIDTH), .NUM_REGS(32), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .reg_wen   (reg_wen),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .init_busy (init_busy)
    );

    register_file #(.WIDTH(WIDTH), .NUM_REGS(8), .ADDR_W(ADDR_W)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .reg_wen   (reg_wen),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd8_data_a),
        .rd_data_b (rd8_data_b),
        .init_busy (init8_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_rd(input string tag, input int port, input logic [WIDTH-1:0] exp);
        sb_entry_t e;
        e.tag  = tag;
        e.port = port;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    // Let combinational reads settle, then drain the scoreboard
    task automatic settle_and_check();
        sb_entry_t e;
        logic [WIDTH-1:0] obs;
        #1;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.port)
                0:       obs = rd_data_a;
                1:       obs = rd_data_b;
                2:       obs = rd8_data_a;
                default: obs = rd8_data_b;
            endcase
            chk(e.tag, {16'h0, obs}, {16'h0, e.exp});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [ADDR_W-1:0] r, input logic [WIDTH-1:0] d);
        reg_wen = 1'b1;
        wr_reg  = r;
        wr_data = d;
        tick();
        reg_wen = 1'b0;
    endtask

    initial begin
        int cnt32;
        int cnt8;
        logic [WIDTH-1:0] bypass_exp;

        rst = 1'b1; reg_wen = 1'b0; wr_reg = '0; wr_data = '0;
        rd_addr_a = 5'd5; rd_addr_b = 5'd0;
        tick();
        chk("reset_busy32", {31'h0, init_busy}, 32'd1);
        chk("reset_busy8", {31'h0, init8_busy}, 32'd1);
        expect_rd("init_forced_a", 0, 16'h0000);
        settle_and_check();

        // Sweep after a one-cycle reset; an external write to r3 lands mid-sweep
        rst = 1'b0;
        cnt32 = 0; cnt8 = 0;
        for (int i = 0; i < 40; i++) begin
            if (init_busy)  cnt32++;
            if (init8_busy) cnt8++;
            if (i == 2) begin
                reg_wen = 1'b1; wr_reg = 5'd3; wr_data = 16'hAAAA;
            end else begin
                reg_wen = 1'b0;
            end
            tick();
        end
        reg_wen = 1'b0;
        chk("sweep_len32", cnt32, 32'd31);
        chk("sweep_len8", cnt8, 32'd7);
        chk("ready_busy32", {31'h0, init_busy}, 32'd0);

        for (int r = 0; r < 32; r++) begin
            rd_addr_a = ADDR_W'(r);
            rd_addr_b = ADDR_W'(31 - r);
            expect_rd($sformatf("zero_a_r%0d", r), 0, 16'h0000);
            expect_rd($sformatf("zero_b_r%0d", 31 - r), 1, 16'h0000);
            expect_rd($sformatf("zero8_a_r%0d", r), 2, 16'h0000);
            settle_and_check();
        end

        write(5'd5, 16'hBEEF);
        rd_addr_a = 5'd5; rd_addr_b = 5'd5;
        expect_rd("r5_a", 0, 16'hBEEF);
        expect_rd("r5_b", 1, 16'hBEEF);
        expect_rd("r5_8a", 2, 16'hBEEF);
        settle_and_check();

        write(5'd0, 16'h1234);
        rd_addr_a = 5'd0;
        expect_rd("r0_a", 0, 16'h0000);
        settle_and_check();

        write(5'd31, 16'hFFFF);
        rd_addr_b = 5'd31;
        expect_rd("r31_b", 1, 16'hFFFF);
        expect_rd("r31_8b_dropped", 3, 16'h0000);
        settle_and_check();

        write(5'd12, 16'h7777);
        rd_addr_a = 5'd12;
        expect_rd("r12_a", 0, 16'h7777);
        expect_rd("r12_8a_dropped", 2, 16'h0000);
        settle_and_check();

        // Same-cycle write/read of r7: bypass shows new data, otherwise old
        write(5'd7, 16'h0011);
`ifdef REGFILE_BYPASS_EN
        bypass_exp = 16'h5A5A;
`else
        bypass_exp = 16'h0011;
`endif
        reg_wen = 1'b1; wr_reg = 5'd7; wr_data = 16'h5A5A;
        rd_addr_a = 5'd7;
        expect_rd("r7_same_cycle", 0, bypass_exp);
        expect_rd("r7_same_cycle8", 2, bypass_exp);
        settle_and_check();
        tick();
        reg_wen = 1'b0;
        expect_rd("r7_next_cycle", 0, 16'h5A5A);
        expect_rd("r7_next_cycle8", 2, 16'h5A5A);
        settle_and_check();

        // Reset mid-sweep restarts the sweep; stored r31 must read as 0 during INIT
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd_addr_a = 5'd31;
        expect_rd("init_forced_r31", 0, 16'h0000);
        settle_and_check();
        cnt32 = 0; cnt8 = 0;
        for (int i = 0; i < 40; i++) begin
            if (init_busy)  cnt32++;
            if (init8_busy) cnt8++;
            tick();
        end
        chk("restart_len32", cnt32, 32'd31);
        chk("restart_len8", cnt8, 32'd7);

        rd_addr_a = 5'd5; rd_addr_b = 5'd31;
        expect_rd("r5_cleared", 0, 16'h0000);
        expect_rd("r31_cleared", 1, 16'h0000);
        expect_rd("r5_cleared8", 2, 16'h0000);
        settle_and_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
